// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared definitions for the WS2812B string transmitter: pixel width,
//   default bit/latch timing in clk cycles (100 MHz) and the FSM state
//   encoding. Imported by the transmitter, its bit timer and the bench.
package ws2812_pkg;

   localparam int PIX_W = 24;

   localparam int T0H_CYC_DEF   = 40;
   localparam int T1H_CYC_DEF   = 80;
   localparam int TBIT_CYC_DEF  = 125;
   localparam int LATCH_CYC_DEF = 6000;

   localparam logic [1:0] ENC_IDLE  = 2'd0;
   localparam logic [1:0] ENC_HIGH  = 2'd1;
   localparam logic [1:0] ENC_LOW   = 2'd2;
   localparam logic [1:0] ENC_LATCH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ENC_IDLE,
      ST_HIGH  = ENC_HIGH,
      ST_LOW   = ENC_LOW,
      ST_LATCH = ENC_LATCH
   } tx_state_t;

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer
//   Loadable down-counter shared by all phases of the transmitter. The
//   owner loads the phase length on every state entry; done is high while
//   the count sits at 1, i.e. in the last cycle of the phase.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-high reset (count <= RST_VAL)
//   load      in   load load_val this cycle
//   load_val  in   phase length in cycles
//   done      out  last cycle of the current phase
module ws2812_bit_timer #(
   parameter int CNT_W   = 13,
   parameter int RST_VAL = 6000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= CNT_W'(RST_VAL);
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/ws2812_string_tx.sv
// ws2812_string_tx
//   Serializes 24-bit GRB pixels (bit 23 first) into the WS2812B NRZ
//   waveform for one LED string, inserting a latch gap after the last pixel
//   of each frame and once after reset.
//
// Build option
//   WS2812_INVERT_EN  drive the pad inverted for an inverting level shifter
//                     (sdi resets to 1); timing and handshake unchanged.
//
// Ports
//   clk           in   pixel clock (100 MHz)
//   rst           in   asynchronous active-high reset
//   pix_data      in   pixel {G,R,B}
//   pix_last      in   pix_data is the last pixel of the frame
//   pix_valid     in   upstream has a pixel
//   pix_ready     out  pixel accepted this cycle when pix_valid is high
//   sdi           out  registered serial line to the string
//   busy          out  not idle
//   underrun      out  sticky: pixel missing mid-frame
//   underrun_clr  in   clears underrun (wins over a same-cycle set)
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line low, waiting for the first pixel of a frame
// HIGH    | high part of the current bit (T1H or T0H by shreg[23])
// LOW     | low part of the current bit; last cycle of bit 0 may
//         | accept the next pixel of the same frame
// LATCH   | line low for LATCH_CYC so the string latches the frame
module ws2812_string_tx
   import ws2812_pkg::*;
#(
   parameter int T0H_CYC   = T0H_CYC_DEF,
   parameter int T1H_CYC   = T1H_CYC_DEF,
   parameter int TBIT_CYC  = TBIT_CYC_DEF,
   parameter int LATCH_CYC = LATCH_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_last,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             sdi,
   output logic             busy,
   output logic             underrun,
   input  logic             underrun_clr
);

   localparam int CNT_MAX = (LATCH_CYC > TBIT_CYC) ? LATCH_CYC : TBIT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(PIX_W);

`ifdef WS2812_INVERT_EN
   localparam logic SDI_INV = 1'b1;
`else
   localparam logic SDI_INV = 1'b0;
`endif

   tx_state_t        state_q, state_d;
   logic [PIX_W-1:0] shreg_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic             last_q;
   logic             underrun_q;
   logic             line_q;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;
   logic             ld_pix;
   logic             shift;
   logic             set_underrun;
   logic             xfer;

   function automatic logic [CNT_W-1:0] high_len(input logic b);
      return b ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
   endfunction

   function automatic logic [CNT_W-1:0] low_len(input logic b);
      return b ? CNT_W'(TBIT_CYC - T1H_CYC) : CNT_W'(TBIT_CYC - T0H_CYC);
   endfunction

   ws2812_bit_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LATCH_CYC)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Ready only depends on registered state, so upstream sees no path
   // from pix_valid back to pix_ready.
   assign pix_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_LOW) && tmr_done &&
                       (bit_idx_q == '0) && !last_q);
   assign xfer      = pix_valid && pix_ready;

   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      ld_pix       = 1'b0;
      shift        = 1'b0;
      set_underrun = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d  = ST_HIGH;
               tmr_load = 1'b1;
               tmr_val  = high_len(pix_data[PIX_W-1]);
               ld_pix   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tmr_done) begin
               state_d  = ST_LOW;
               tmr_load = 1'b1;
               tmr_val  = low_len(shreg_q[PIX_W-1]);
            end
         end
         ST_LOW: begin
            if (tmr_done) begin
               if (bit_idx_q != '0) begin
                  // next bit is the one that moves into bit 23 on the shift
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
                  tmr_val  = high_len(shreg_q[PIX_W-2]);
                  shift    = 1'b1;
               end else if (last_q) begin
                  state_d  = ST_LATCH;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(LATCH_CYC);
               end else if (xfer) begin
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
                  tmr_val  = high_len(pix_data[PIX_W-1]);
                  ld_pix   = 1'b1;
               end else begin
                  // frame position is kept; the next pixel continues it
                  state_d      = ST_IDLE;
                  set_underrun = 1'b1;
               end
            end
         end
         ST_LATCH: begin
            if (tmr_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_LATCH;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(LATCH_CYC);
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_LATCH;
         line_q     <= SDI_INV;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         last_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // registered from next state so sdi rises on the accepting edge
         line_q  <= (state_d == ST_HIGH) ^ SDI_INV;
         if (ld_pix) begin
            shreg_q   <= pix_data;
            last_q    <= pix_last;
            bit_idx_q <= IDX_W'(PIX_W - 1);
         end else if (shift) begin
            shreg_q   <= {shreg_q[PIX_W-2:0], 1'b0};
            bit_idx_q <= bit_idx_q - 1'b1;
         end
         if (underrun_clr) begin
            underrun_q <= 1'b0;
         end else if (set_underrun) begin
            underrun_q <= 1'b1;
         end
      end
   end

   assign sdi      = line_q;
   assign busy     = (state_q != ST_IDLE);
   assign underrun = underrun_q;

endmodule

// File: tb/tb_ws2812_string_tx.sv
// tb_ws2812_string_tx
//   Directed sequence with random pixel values. A negedge monitor compares
//   sdi, pix_ready, busy and underrun every cycle against a waveform model:
//   each accepted pixel appends its per-cycle line levels (and the latch gap
//   for a last pixel) to a queue that is consumed one entry per clock.
module tb_ws2812_string_tx;
   import ws2812_pkg::*;

`ifdef WS2812_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [PIX_W-1:0] pix_data = '0;
   logic             pix_last = 1'b0;
   logic             pix_valid = 1'b0;
   logic             underrun_clr = 1'b0;
   logic             pix_ready;
   logic             sdi;
   logic             busy;
   logic             underrun;

   int    checks = 0;
   int    errors = 0;
   longint cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ws2812_string_tx dut (
      .clk          (clk),
      .rst          (rst),
      .pix_data     (pix_data),
      .pix_last     (pix_last),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .sdi          (sdi),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   // ---------------- reference model ----------------
   bit exp_q[$];
   bit tail_latch;
   bit und_m;

   task automatic model_reset();
      exp_q.delete();
      repeat (LATCH_CYC_DEF) exp_q.push_back(1'b0);
      tail_latch = 1'b1;
      und_m      = 1'b0;
   endtask

   task automatic model_pixel(input logic [PIX_W-1:0] d, input logic l);
      for (int b = PIX_W - 1; b >= 0; b--) begin
         int h;
         h = d[b] ? T1H_CYC_DEF : T0H_CYC_DEF;
         repeat (h) exp_q.push_back(1'b1);
         repeat (TBIT_CYC_DEF - h) exp_q.push_back(1'b0);
      end
      if (l) repeat (LATCH_CYC_DEF) exp_q.push_back(1'b0);
      tail_latch = l;
   endtask

   always @(negedge clk) begin
      bit lvl, rdy, bsy, xfer, set_u;
      if (rst) model_reset();
      lvl = (exp_q.size() != 0) ? exp_q[0] : 1'b0;
      rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && !tail_latch);
      bsy = (exp_q.size() != 0);
      checks++;
      assert (sdi === (lvl ^ INV)) else begin
         errors++;
         $error("FAIL mon_sdi cyc=%0d observed=%b expected=%b", cyc, sdi, lvl ^ INV);
      end
      checks++;
      assert (pix_ready === rdy) else begin
         errors++;
         $error("FAIL mon_pix_ready cyc=%0d observed=%b expected=%b", cyc, pix_ready, rdy);
      end
      checks++;
      assert (busy === bsy) else begin
         errors++;
         $error("FAIL mon_busy cyc=%0d observed=%b expected=%b", cyc, busy, bsy);
      end
      checks++;
      assert (underrun === und_m) else begin
         errors++;
         $error("FAIL mon_underrun cyc=%0d observed=%b expected=%b", cyc, underrun, und_m);
      end
      if (!rst) begin
         xfer  = pix_valid && rdy;
         set_u = (exp_q.size() == 1) && !tail_latch && !xfer;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (xfer) model_pixel(pix_data, pix_last);
         und_m = underrun_clr ? 1'b0 : (set_u ? 1'b1 : und_m);
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [PIX_W-1:0] d, input logic l, output longint t);
      int n;
      n = 0;
      pix_data  = d;
      pix_last  = l;
      pix_valid = 1'b1;
      while (!pix_ready && n < 20000) begin
         step();
         n++;
      end
      chk("send_accept", {63'd0, pix_ready}, 64'd1);
      @(posedge clk);
      #1;
      t = cyc;
   endtask

   task automatic count_until_ready(input int budget, output int n);
      n = 0;
      while (!pix_ready && n < budget) begin
         step();
         n++;
      end
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      longint t1, t2, t3, t4;
      int     n, hi, nrdy, k;
      logic [PIX_W-1:0] p;

      #2 rst = 1'b1;
      #1;
      chk("reset_sdi", {63'd0, sdi}, {63'd0, INV});
      chk("reset_ready", {63'd0, pix_ready}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd1);
      repeat (5) step();
      rst = 1'b0;

      // power-up latch gap
      count_until_ready(8000, n);
      chk("reset_latch_len", 64'(n), 64'(LATCH_CYC_DEF));
      chk("reset_idle_busy", {63'd0, busy}, 64'd0);

      // single pixel A5_0F_80, last
      send(24'hA50F80, 1'b1, t1);
      pix_valid = 1'b0;
      chk("single_first_high", {63'd0, sdi ^ INV}, 64'd1);
      hi = 0;
      for (int i = 0; i < PIX_W * TBIT_CYC_DEF; i++) begin
         hi += int'(sdi ^ INV);
         step();
      end
      chk("single_high_total", 64'(hi), 64'(9 * T1H_CYC_DEF + 15 * T0H_CYC_DEF));
      count_until_ready(8000, n);
      chk("single_latch_len", 64'(n), 64'(LATCH_CYC_DEF));

      // four back-to-back random pixels, valid held
      send($urandom, 1'b0, t1);
      send($urandom, 1'b0, t2);
      chk("b2b_period_12", 64'(t2 - t1), 64'(PIX_W * TBIT_CYC_DEF));
      send($urandom, 1'b0, t3);
      chk("b2b_period_23", 64'(t3 - t2), 64'(PIX_W * TBIT_CYC_DEF));
      send($urandom, 1'b1, t4);
      chk("b2b_period_34", 64'(t4 - t3), 64'(PIX_W * TBIT_CYC_DEF));
      // valid/data noise while not ready must be ignored
      k = 0;
      nrdy = 0;
      while (busy && k < 20000) begin
         if (k < 2000) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = $urandom;
            pix_last  = 1'($urandom_range(0, 1));
         end else begin
            pix_valid = 1'b0;
         end
         nrdy += int'(pix_ready);
         step();
         k++;
      end
      pix_valid = 1'b0;
      chk("b2b_tail_busy_len", 64'(k), 64'(PIX_W * TBIT_CYC_DEF + LATCH_CYC_DEF));
      chk("b2b_tail_no_ready", 64'(nrdy), 64'd0);

      // underrun after pixel 2 of 4
      send($urandom, 1'b0, t1);
      send($urandom, 1'b0, t2);
      pix_valid = 1'b0;
      n = 0;
      while (busy && n < 5000) begin
         step();
         n++;
      end
      chk("underrun_idle_delay", 64'(n), 64'(PIX_W * TBIT_CYC_DEF));
      chk("underrun_set", {63'd0, underrun}, 64'd1);
      repeat (200) step();
      chk("underrun_gap_sdi", {63'd0, sdi}, {63'd0, INV});
      chk("underrun_sticky", {63'd0, underrun}, 64'd1);
      underrun_clr = 1'b1;
      step();
      underrun_clr = 1'b0;
      chk("underrun_clr", {63'd0, underrun}, 64'd0);
      p = $urandom;
      send(p, 1'b0, t3);
      pix_valid = 1'b0;
      n = 0;
      while (!(pix_ready && busy) && n < 5000) begin
         step();
         n++;
      end
      chk("underrun_final_low", 64'(n), 64'(PIX_W * TBIT_CYC_DEF - 1));
      underrun_clr = 1'b1;
      step();
      underrun_clr = 1'b0;
      chk("underrun_set_clr", {63'd0, underrun}, 64'd0);
      chk("underrun_idle2", {63'd0, busy}, 64'd0);
      repeat (200) step();
      send($urandom, 1'b1, t4);
      pix_valid = 1'b0;
      count_until_ready(12000, n);
      chk("underrun_resume_len", 64'(n), 64'(PIX_W * TBIT_CYC_DEF + LATCH_CYC_DEF));

      // reset 10 cycles into a HIGH phase
      send(24'h800000 | PIX_W'($urandom), 1'b0, t1);
      pix_valid = 1'b0;
      repeat (10) step();
      chk("midbit_high", {63'd0, sdi ^ INV}, 64'd1);
      rst = 1'b1;
      #1;
      chk("midbit_async_sdi", {63'd0, sdi}, {63'd0, INV});
      chk("midbit_ready", {63'd0, pix_ready}, 64'd0);
      repeat (3) step();
      rst = 1'b0;
      count_until_ready(8000, n);
      chk("midbit_latch_len", 64'(n), 64'(LATCH_CYC_DEF));
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
